uart_tx_sched: RTL

Scheduler between the byte FIFO and the UART transmitter. It round-robin arbitrates two byte producers onto the FIFO write port, then drains the FIFO into the transmitter one frame at a time with an inter-frame gap. Draining runs either continuously (auto mode) or in bounded bursts started by a debounced trigger pulse. It replaces direct button-driven popping of the FIFO.

---
 rtl/uart_tx_sched.sv | 135 +++++++++++++
 1 files changed

// File: rtl/uart_tx_sched.sv
// Sits between the byte FIFO and the UART transmitter: round-robin merges two producers
// into the FIFO and drains it one frame at a time with an enforced inter-frame gap.
module uart_tx_sched #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned BURST_MAX  = 8
) (
    input  logic                  sample_Clk,
    input  logic                  reset,
    input  logic                  req0_Valid,
    input  logic [DATA_WIDTH-1:0] req0_Data,
    output logic                  req0_Ready,
    input  logic                  req1_Valid,
    input  logic [DATA_WIDTH-1:0] req1_Data,
    output logic                  req1_Ready,
    output logic                  fifo_Wr,
    output logic [DATA_WIDTH-1:0] fifo_WrData,
    input  logic                  fifo_Full,
    input  logic                  fifo_Empty,
    output logic                  fifo_Rd,
    input  logic [DATA_WIDTH-1:0] fifo_RdData,
    output logic                  tx_Start,
    output logic [DATA_WIDTH-1:0] tx_Data,
    input  logic                  tx_Busy,
    input  logic                  auto_Mode,
    input  logic                  burst_Trig,
    output logic                  sched_Busy,
    output logic [7:0]            sent_Count
);

    typedef enum logic [2:0] {StIdle, StFetch, StLoad, StStart, StWait, StGap} state_e;

    localparam logic [7:0] GapLast  = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] BurstLen = 8'(BURST_MAX);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [7:0]            sent_q, sent_d;
    logic [7:0]            burst_q, burst_d;
    logic [7:0]            gap_q, gap_d;
    logic                  last_grant_q, last_grant_d;
    logic                  mode_q, mode_d;

    logic grant0, grant1, wr_en, rd_en, start;

    // last_grant_q=1 means req1 was served last, so req0 wins the next tie.
    always_comb begin
        grant0       = req0_Valid && (!req1_Valid || last_grant_q);
        grant1       = req1_Valid && (!req0_Valid || !last_grant_q);
        rd_en        = (state_q == StFetch);
        // Never write during a pop: the FIFO would favour the write and lose the pop.
        wr_en        = reset && !fifo_Full && !rd_en && (grant0 || grant1);
        req0_Ready   = wr_en && grant0;
        req1_Ready   = wr_en && grant1;
        fifo_Wr      = wr_en;
        fifo_WrData  = wr_en ? (grant0 ? req0_Data : req1_Data) : '0;
        last_grant_d = wr_en ? grant1 : last_grant_q;
    end

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        gap_d     = gap_q;
        mode_d    = mode_q;
        start     = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_Empty && (auto_Mode || burst_q != 8'd0)) begin
                    state_d = StFetch;
                    mode_d  = auto_Mode;
                end
            end
            StFetch: state_d = StLoad;
            StLoad: begin
                tx_data_d = fifo_RdData;
                state_d   = StStart;
            end
            StStart: begin
                if (!tx_Busy) begin
                    start   = 1'b1;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (!tx_Busy) begin
                    state_d = StGap;
                    gap_d   = 8'd0;
                end
            end
            StGap: begin
                if (gap_q == GapLast) state_d = StIdle;
                else                  gap_d   = gap_q + 8'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    // A trigger reload wins over a same-cycle pop decrement.
    always_comb begin
        burst_d = burst_q;
        if (burst_Trig) begin
            burst_d = BurstLen;
        end else if (rd_en && !mode_q && burst_q != 8'd0) begin
            burst_d = burst_q - 8'd1;
        end
        sent_d = start ? sent_q + 8'd1 : sent_q;
    end

    always_ff @(posedge sample_Clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            tx_data_q    <= '1;
            sent_q       <= 8'd0;
            burst_q      <= 8'd0;
            gap_q        <= 8'd0;
            last_grant_q <= 1'b1;
            mode_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            sent_q       <= sent_d;
            burst_q      <= burst_d;
            gap_q        <= gap_d;
            last_grant_q <= last_grant_d;
            mode_q       <= mode_d;
        end
    end

    assign fifo_Rd    = rd_en;
    assign tx_Start   = start;
    assign tx_Data    = tx_data_q;
    assign sched_Busy = (state_q != StIdle);
    assign sent_Count = sent_q;

endmodule
